// File: rtl/dds_sram_pkg.sv
// Shared encodings for the multi-channel SRAM DDS: waveform modes, controller
// states and the sample pipeline latency.
package dds_sram_pkg;

  typedef enum logic [1:0] {
    MODE_TABLE  = 2'd0,
    MODE_SAW    = 2'd1,
    MODE_SQUARE = 2'd2,
    MODE_TRI    = 2'd3
  } mode_e;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int PIPE_LATENCY = 2;

endpackage

// File: rtl/dds_lut_sram.sv
// Single-port synchronous sine table; one address serves both the load-time
// writes and the run-time reads.
module dds_lut_sram #(
  parameter int ADDR_W = 12,
  parameter int AMP_W  = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [AMP_W-1:0]  wdata,
  output logic [AMP_W-1:0]  rdata
);

  logic [AMP_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dds_sram_mc.sv
// Multi-channel DDS: one loaded sine table shared round-robin by CHANNELS phase
// accumulators, each with its own FCW, offset, enable and waveform mode.
module dds_sram_mc
  import dds_sram_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int PHASE_W  = 32,
  parameter int ADDR_W   = 12,
  parameter int AMP_W    = 16
) (
  input  logic                        sys_clk,
  input  logic                        reset,
  input  logic [CHANNELS*PHASE_W-1:0] fcw,
  input  logic [CHANNELS*PHASE_W-1:0] offset,
  input  logic [CHANNELS*2-1:0]       mode,
  input  logic [CHANNELS-1:0]         ch_en,
  input  logic                        sync_clr,
  input  logic                        reload,
  input  logic                        load_valid,
  input  logic [AMP_W-1:0]            load_data,
  output logic                        load_ready,
  output logic                        writed_,
  output logic [CHANNELS*AMP_W-1:0]   amp_out,
  output logic [CHANNELS-1:0]         amp_valid
);

  localparam int SLOT_W = $clog2(CHANNELS);

  state_e              state, state_next;
  logic                ready_q;
  logic [ADDR_W-1:0]   load_addr;
  logic                load_hs;
  logic                reload_run;
  logic                run_issue;

  logic [SLOT_W-1:0]   slot;
  logic [PHASE_W-1:0]  acc [CHANNELS];
  logic [PHASE_W-1:0]  cur_fcw, cur_off, cur_acc, phase0;
  logic                cur_en;
  mode_e               cur_mode;
  logic                unused_phase;

  logic                s1_valid, s1_en;
  logic [SLOT_W-1:0]   s1_ch;
  mode_e               s1_mode;
  logic [AMP_W-1:0]    s1_u;
  logic [AMP_W-1:0]    tri_base, wave;

  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [AMP_W-1:0]    ram_q;

  logic [CHANNELS*AMP_W-1:0] amp_q;
  logic [CHANNELS-1:0]       valid_q;

  assign load_hs    = (state == ST_LOAD) && load_valid && ready_q;
  assign reload_run = (state == ST_RUN) && reload;
  assign run_issue  = (state == ST_RUN) && !reload;

  always_comb begin
    state_next = state;
    case (state)
      ST_LOAD: if (load_hs && load_addr == {ADDR_W{1'b1}}) state_next = ST_RUN;
      ST_RUN:  if (reload) state_next = ST_LOAD;
      default: state_next = ST_LOAD;
    endcase
  end

  // ready is registered so it stays low through reset and rises one clock later
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_LOAD;
      ready_q   <= 1'b0;
      load_addr <= '0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next == ST_LOAD);
      if (load_hs)               load_addr <= load_addr + 1'b1;
      else if (state == ST_RUN)  load_addr <= '0;
    end
  end

  always_comb begin
    cur_fcw  = '0;
    cur_off  = '0;
    cur_acc  = '0;
    cur_en   = 1'b0;
    cur_mode = MODE_TABLE;
    for (int k = 0; k < CHANNELS; k++) begin
      if (slot == SLOT_W'(k)) begin
        cur_fcw  = fcw[k*PHASE_W +: PHASE_W];
        cur_off  = offset[k*PHASE_W +: PHASE_W];
        cur_acc  = acc[k];
        cur_en   = ch_en[k];
        cur_mode = mode_e'(mode[k*2 +: 2]);
      end
    end
    phase0 = cur_acc + cur_off;
  end

  assign unused_phase = ^phase0;

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      slot <= '0;
      for (int k = 0; k < CHANNELS; k++) acc[k] <= '0;
    end else if (!run_issue || sync_clr) begin
      slot <= '0;
      for (int k = 0; k < CHANNELS; k++) acc[k] <= '0;
    end else begin
      slot <= slot + 1'b1;
      for (int k = 0; k < CHANNELS; k++)
        if (slot == SLOT_W'(k)) acc[k] <= cur_en ? acc[k] + cur_fcw : '0;
    end
  end

  assign ram_we   = load_hs;
  assign ram_addr = (state == ST_LOAD) ? load_addr : phase0[PHASE_W-1 -: ADDR_W];

  dds_lut_sram #(.ADDR_W(ADDR_W), .AMP_W(AMP_W)) u_lut (
    .clk   (sys_clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (load_data),
    .rdata (ram_q)
  );

  // stage 1 travels alongside the SRAM read
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_en    <= 1'b0;
      s1_ch    <= '0;
      s1_mode  <= MODE_TABLE;
      s1_u     <= '0;
    end else begin
      s1_valid <= run_issue;
      s1_en    <= cur_en;
      s1_ch    <= slot;
      s1_mode  <= cur_mode;
      s1_u     <= phase0[PHASE_W-1 -: AMP_W];
    end
  end

  assign tri_base = {s1_u[AMP_W-2:0], 1'b0};

  always_comb begin
    wave = ram_q;
    case (s1_mode)
      MODE_TABLE:  wave = ram_q;
      MODE_SAW:    wave = s1_u;
      MODE_SQUARE: wave = s1_u[AMP_W-1] ? '0 : '1;
      MODE_TRI:    wave = s1_u[AMP_W-1] ? ~tri_base : tri_base;
      default:     wave = ram_q;
    endcase
  end

  // a reload drops whatever is in stage 1 but leaves amp_out untouched
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      amp_q   <= '0;
      valid_q <= '0;
    end else begin
      valid_q <= '0;
      if (s1_valid && !reload_run) begin
        for (int k = 0; k < CHANNELS; k++) begin
          if (s1_ch == SLOT_W'(k)) begin
            amp_q[k*AMP_W +: AMP_W] <= s1_en ? wave : '0;
            valid_q[k]              <= s1_en;
          end
        end
      end
    end
  end

  assign load_ready = ready_q;
  assign writed_    = (state == ST_RUN);
  assign amp_out    = amp_q;
  assign amp_valid  = valid_q;

endmodule

// File: tb/tb_dds_sram_mc.sv
// Directed bench for dds_sram_mc: table load/abort, per-channel waveforms,
// channel enable, sync clear and reload, with hand-derived expected samples.
module tb_dds_sram_mc;
  import dds_sram_pkg::*;

  localparam int CH = 4;
  localparam int PW = 32;
  localparam int MW = 16;

  logic             sys_clk;
  logic             reset;
  logic [CH*PW-1:0] fcw, offset;
  logic [CH*2-1:0]  mode;
  logic [CH-1:0]    ch_en;
  logic             sync_clr, reload, load_valid;
  logic [MW-1:0]    load_data;
  logic             load_ready, writed_;
  logic [CH*MW-1:0] amp_out;
  logic [CH-1:0]    amp_valid;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] cfg_fcw  [CH];
  logic [31:0] cfg_off  [CH];
  logic [1:0]  cfg_mode [CH];
  logic [15:0] mask;
  int          hs, early;

  dds_sram_mc #(.CHANNELS(CH), .PHASE_W(PW), .ADDR_W(12), .AMP_W(MW)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .fcw        (fcw),
    .offset     (offset),
    .mode       (mode),
    .ch_en      (ch_en),
    .sync_clr   (sync_clr),
    .reload     (reload),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .writed_    (writed_),
    .amp_out    (amp_out),
    .amp_valid  (amp_valid)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic pushCfg();
    for (int k = 0; k < CH; k++) begin
      fcw[k*PW +: PW]    = cfg_fcw[k];
      offset[k*PW +: PW] = cfg_off[k];
      mode[k*2 +: 2]     = cfg_mode[k];
    end
  endtask

  function automatic logic [15:0] ampOf(input int k);
    return amp_out[k*MW +: MW];
  endfunction

  // table content is addr ^ mask; other modes follow the waveform definitions
  function automatic logic [15:0] expWave(input logic [1:0] m, input logic [31:0] p);
    logic [15:0] u;
    logic [15:0] dbl;
    u   = p[31:16];
    dbl = {u[14:0], 1'b0};
    case (m)
      2'd0:    return {4'h0, p[31:20]} ^ mask;
      2'd1:    return u;
      2'd2:    return p[31] ? 16'h0000 : 16'hFFFF;
      default: return p[31] ? ~dbl : dbl;
    endcase
  endfunction

  function automatic logic [15:0] expSample(input int k, input int n);
    logic [31:0] nn;
    nn = 32'(n);
    return expWave(cfg_mode[k], nn * cfg_fcw[k] + cfg_off[k]);
  endfunction

  task automatic loadTable(input int limit, input logic [15:0] msk,
                           output int hs_out, output int early_out);
    int   cycles;
    logic tog, rdy;
    hs_out = 0; early_out = 0; cycles = 0; tog = 1'b0;
    while (hs_out < limit && cycles < 20000) begin
      if (writed_) early_out++;
      tog        = ~tog;
      load_valid = tog;
      load_data  = 16'(hs_out) ^ msk;
      rdy        = load_ready;
      applyStimulus(1);
      if (tog && rdy) hs_out++;
      cycles++;
    end
    load_valid = 1'b0;
  endtask

  task automatic checkFullLoad(input string tag);
    checkOutput({tag, "_handshakes"}, 32'(hs), 32'd4096);
    checkOutput({tag, "_early_run"}, 32'(early), 32'd0);
    checkOutput({tag, "_writed"}, 32'(writed_), 32'd1);
    checkOutput({tag, "_ready_low"}, 32'(load_ready), 32'd0);
  endtask

  // d counts cycles from the slot-0 cycle; channel k output lands at 4n+k+latency
  task automatic runCheck(input int first_d, input int last_d);
    int k, n;
    for (int d = first_d; d <= last_d; d++) begin
      if (d < PIPE_LATENCY) begin
        checkOutput($sformatf("idle_valid_d%0d", d), 32'(amp_valid), 32'd0);
      end else begin
        k = (d - PIPE_LATENCY) % CH;
        n = (d - PIPE_LATENCY) / CH;
        checkOutput($sformatf("valid_d%0d", d), 32'(amp_valid), 32'(1 << k));
        checkOutput($sformatf("ch%0d_n%0d", k, n), 32'(ampOf(k)), 32'(expSample(k, n)));
      end
      applyStimulus(1);
    end
  endtask

  initial begin
    logic [31:0] exp_valid;
    reset = 1'b0; sync_clr = 1'b0; reload = 1'b0;
    load_valid = 1'b0; load_data = '0; ch_en = 4'hF; mask = 16'h0000;
    fcw = '0; offset = '0; mode = '0;
    cfg_fcw[0] = 32'h0100_0000; cfg_off[0] = 32'h0;          cfg_mode[0] = 2'd0;
    cfg_fcw[1] = 32'h0100_0000; cfg_off[1] = 32'h8000_0000;  cfg_mode[1] = 2'd0;
    cfg_fcw[2] = 32'h0100_0000; cfg_off[2] = 32'h0;          cfg_mode[2] = 2'd1;
    cfg_fcw[3] = 32'h2000_0000; cfg_off[3] = 32'h0;          cfg_mode[3] = 2'd2;
    pushCfg();

    #2;
    checkOutput("rst_writed", 32'(writed_), 32'd0);
    checkOutput("rst_ready", 32'(load_ready), 32'd0);
    checkOutput("rst_valid", 32'(amp_valid), 32'd0);
    checkOutput("rst_amp", 32'(amp_out[31:0] | amp_out[63:32]), 32'd0);
    applyStimulus(3);
    reset = 1'b1;
    checkOutput("release_ready", 32'(load_ready), 32'd0);
    applyStimulus(1);
    checkOutput("first_ready", 32'(load_ready), 32'd1);

    loadTable(1000, 16'h0000, hs, early);
    checkOutput("partial_hs", 32'(hs), 32'd1000);
    reset = 1'b0;
    #1;
    checkOutput("abort_writed", 32'(writed_), 32'd0);
    checkOutput("abort_ready", 32'(load_ready), 32'd0);
    applyStimulus(2);
    reset = 1'b1;

    loadTable(4096, mask, hs, early);
    checkFullLoad("load1");
    runCheck(0, 33);

    // channel 2 disabled for its slots at cycles 34, 38, 42
    ch_en[2] = 1'b0;
    for (int c = 34; c <= 53; c++) begin
      if (c == 46) ch_en[2] = 1'b1;
      exp_valid = (c == 36 || c == 40 || c == 44) ? 32'd0 : 32'(1 << ((c - 2) % CH));
      checkOutput($sformatf("en_valid_c%0d", c), 32'(amp_valid), exp_valid);
      if (c == 36 || c == 40 || c == 44 || c == 48)
        checkOutput($sformatf("ch2_off_c%0d", c), 32'(ampOf(2)), 32'd0);
      if (c == 52)
        checkOutput("ch2_resume", 32'(ampOf(2)), 32'h0100);
      applyStimulus(1);
    end

    sync_clr = 1'b1;
    cfg_mode[3] = 2'd3;
    pushCfg();
    checkOutput("clr_valid_c54", 32'(amp_valid), 32'd1);
    applyStimulus(1);
    sync_clr = 1'b0;
    checkOutput("clr_inflight1_valid", 32'(amp_valid), 32'd2);
    checkOutput("clr_inflight1_ch1", 32'(ampOf(1)), 32'd2256);
    applyStimulus(1);
    checkOutput("clr_inflight2_valid", 32'(amp_valid), 32'd4);
    checkOutput("clr_inflight2_ch2", 32'(ampOf(2)), 32'h0200);
    applyStimulus(1);
    runCheck(2, 21);

    reload = 1'b1;
    sync_clr = 1'b1;
    checkOutput("reload_c_valid", 32'(amp_valid), 32'd1);
    applyStimulus(1);
    reload = 1'b0;
    sync_clr = 1'b0;
    checkOutput("reload_writed", 32'(writed_), 32'd0);
    checkOutput("reload_ready", 32'(load_ready), 32'd1);
    checkOutput("reload_drop1", 32'(amp_valid), 32'd0);
    checkOutput("hold_ch0", 32'(ampOf(0)), 32'(expSample(0, 5)));
    checkOutput("hold_ch1", 32'(ampOf(1)), 32'(expSample(1, 4)));
    checkOutput("hold_ch2", 32'(ampOf(2)), 32'(expSample(2, 4)));
    checkOutput("hold_ch3", 32'(ampOf(3)), 32'hFFFF);
    applyStimulus(1);
    checkOutput("reload_drop2", 32'(amp_valid), 32'd0);
    checkOutput("hold2_ch3", 32'(ampOf(3)), 32'hFFFF);

    mask = 16'h5A5A;
    loadTable(4096, mask, hs, early);
    checkFullLoad("load2");
    runCheck(0, 13);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dds_sram_mc.md
Name: dds_sram_mc

Overview:
Multi-channel successor to the single-channel SRAM-based DDS. One shared sine table (2^ADDR_W x AMP_W) is loaded through a valid/ready port, then serves CHANNELS phase accumulators time-multiplexed round-robin. Each channel has its own FCW, phase offset, enable and waveform mode (table, saw, square, triangle). It sits between the control register block and the DAC sample formatter.

Parameters:
CHANNELS, 4, number of phase channels (power of 2, >=2)
PHASE_W, 32, accumulator / FCW / offset width
ADDR_W, 12, table address width (table depth 2^ADDR_W)
AMP_W, 16, sample width (unsigned offset-binary); AMP_W <= PHASE_W-1

Ports:
sys_clk  in  1  clock
reset  in  1  asynchronous active-low reset
fcw  in  CHANNELS*PHASE_W  per-channel frequency control word, channel k at [k*PHASE_W +: PHASE_W]
offset  in  CHANNELS*PHASE_W  per-channel phase offset, same packing
mode  in  CHANNELS*2  per-channel waveform: 0 table, 1 saw, 2 square, 3 triangle
ch_en  in  CHANNELS  per-channel enable
sync_clr  in  1  synchronous clear of all accumulators and slot counter
reload  in  1  pulse: discard table, return to LOAD
load_valid  in  1  table word valid
load_data  in  AMP_W  table word
load_ready  out  1  table port ready
writed_  out  1  high: table fully loaded, generation running (active high)
amp_out  out  CHANNELS*AMP_W  per-channel sample
amp_valid  out  CHANNELS  per-channel one-cycle sample strobe

Behaviour:
- Reset (reset=0, async): state=LOAD, load address=0, all accumulators=0, slot=0, writed_=0, load_ready=0, amp_out=0, amp_valid=0, pipeline flushed. Table contents undefined. load_ready rises first clock after release.
- FSM LOAD: load_ready=1; each cycle with load_valid&load_ready writes load_data at load address, address increments. The handshake at address 2^ADDR_W-1 moves to RUN; load_ready=0 and writed_=1 from the next cycle. Slot=0, accumulators=0 on entry.
- FSM RUN: load_ready=0, load_valid ignored. reload=1 -> LOAD next cycle: writed_=0, address=0, accumulators=0, in-flight samples dropped (no amp_valid), amp_out keeps last values. reload ignored in LOAD.
- Slot counter: 0..CHANNELS-1, +1 per RUN cycle, wraps. Channel k serviced once per CHANNELS cycles.
- Slot cycle for channel k (stage 0): p = acc[k]+offset[k] mod 2^PHASE_W using the pre-update acc; acc[k] <= acc[k]+fcw[k] mod 2^PHASE_W. Table address = p[PHASE_W-1 -: ADDR_W] (truncation, no rounding).
- Stage 1: synchronous SRAM read; mode and p pipelined alongside.
- Stage 2: amp_out[k] registered, amp_valid[k]=1 for one cycle. Latency = 2 cycles after slot cycle for all modes.
- Mode values (u = p[PHASE_W-1 -: AMP_W]): table = SRAM data; saw = u; square = p MSB ? 0 : 2^AMP_W-1; triangle = p MSB ? ~(u<<1) : (u<<1), AMP_W bits.
- fcw/offset/mode sampled at the channel's slot cycle only; changes take effect at its next slot.
- ch_en[k]=0 at slot: acc[k] <= 0, no amp_valid[k], amp_out[k] <= 0 at stage 2. Re-enable resumes from phase 0.
- sync_clr=1: all accumulators <= 0 and slot <= 0 next cycle, overriding the increment; stage 0 in the same cycle still issues. Samples already in flight complete normally.
- sync_clr and reload together: reload wins.

Decomposition:
- Package dds_sram_pkg: mode encodings (MODE_TABLE=0, MODE_SAW=1, MODE_SQUARE=2, MODE_TRI=3), state encoding (ST_LOAD, ST_RUN), pipeline latency constant (2).
- Sub-module dds_lut_sram: single-port synchronous RAM, 2^ADDR_W x AMP_W, write port from LOAD, read port from RUN (exclusive by state, one address mux).

Test Plan:
- Load ramp table data=addr, 4096 words, load_valid toggled every other cycle -> exactly 4096 handshakes, load_ready drops and writed_ rises the cycle after the last; table readback via mode 0 matches.
- CHANNELS=4, ch0 fcw=32'h01000000, offset=0, mode 0 -> ch0 samples 0,16,32,48,... (address step 16 per frame), amp_valid[0] every 4 cycles, first strobe 2 cycles after first slot.
- ch1 fcw=32'h01000000, offset=32'h80000000, ch2 mode 1, ch3 mode 2 -> ch1 = ch0+2048 mod 4096, ch2 = phase[31:16] sequence 0,0x0100,..., ch3 = 0xFFFF then 0x0000 once MSB sets.
- ch_en[2] deasserted for 3 frames, sync_clr pulsed mid-run -> no amp_valid[2], amp_out[2]=0, ch2 restarts at phase 0; after sync_clr all channels restart at phase 0 from slot 0.
- reset pulled low at address 1000 during load -> writed_=0, load_ready=0 immediately; after release load restarts at address 0 and needs a full 4096 words.
- reload in RUN with sync_clr same cycle -> LOAD next cycle, writed_=0, in-flight amp_valid suppressed, amp_out held; full reload returns to RUN with phase 0.
